pifo_reg_array: RTL and testbench
=================================

# pifo_reg_array

Register-based storage array that sits directly upstream of the PIFO max-selection tree. It holds up to REG_WIDTH ranked entries and presents them, flattened, to the tree's first stage. It accepts new entries through a valid/ready enqueue port and, on dequeue, removes the slot index returned by the tree. It then delivers that entry's rank and metadata one cycle later.

## Interface
Parameters:
- REG_WIDTH, 4: number of slots; power of two, ≥2
- DATA_WIDTH, 8: rank width; larger rank = higher priority
- META_WIDTH, 10: opaque metadata width
- IDX_WIDTH, 2: slot index width, = clog2(REG_WIDTH)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- ins_vld  in  1  enqueue request
- ins_rdy  out  1  enqueue accepted this cycle when high with ins_vld
- ins_data  in  DATA_WIDTH  rank to store
- ins_meta  in  META_WIDTH  metadata to store
- deq_req  in  1  dequeue request
- deq_rdy  out  1  dequeue accepted this cycle when high with deq_req
- deq_vld  out  1  one-cycle pulse: deq_data/deq_meta valid
- deq_data  out  DATA_WIDTH  removed rank
- deq_meta  out  META_WIDTH  removed metadata
- data_out  out  REG_WIDTH*DATA_WIDTH  slot ranks to tree, slot i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- meta_out  out  REG_WIDTH*META_WIDTH  slot metadata to tree, same packing
- idx_out  out  REG_WIDTH*IDX_WIDTH  constant slot numbers, field i = i
- vld_out  out  REG_WIDTH  slot occupied flags
- sel_idx  in  IDX_WIDTH  winning slot from tree root
- sel_vld  in  1  tree root valid
- count  out  IDX_WIDTH+1  occupied slots

## Operation
- Storage: per-slot registers data, meta, vld. data_out, meta_out and vld_out are driven directly from these registers; no logic sits between them and the tree.
- ins_rdy = !full, where full = (count == REG_WIDTH). There is no full-with-dequeue bypass.
- Insert (ins_vld && ins_rdy): write into the lowest-index slot whose vld is 0, evaluated on the pre-edge vld. A slot freed by a same-cycle dequeue is not reused that cycle.
- deq_rdy = sel_vld && vld[sel_idx]. This is 0 when the array is empty.
- Dequeue (deq_req && deq_rdy): clear vld[sel_idx]. Register the slot's data and meta into deq_data and deq_meta, and assert deq_vld for one cycle.
- The winner is always computed from pre-edge contents. An entry inserted in cycle N is eligible from cycle N+1.
- Insert and dequeue in the same cycle are both honoured; count is unchanged. Otherwise count is +1 on insert and −1 on dequeue.
- Ties are resolved solely by sel_idx; this block applies no ordering of its own.
- deq_data and deq_meta hold their last value when deq_vld=0.

## Timing
- Reset values: all vld=0, slot data/meta=0, count=0, deq_vld=0, deq_data=0, deq_meta=0. Consequently ins_rdy=1 and deq_rdy=0 after reset.
- Reset mid-operation: rst overrides everything in the same edge. An accepted dequeue is dropped (deq_vld=0 on the following cycle) and an accepted insert is lost.
- Enqueue latency: 1 cycle to vld_out/count.
- Dequeue latency: 1 cycle, accept edge to deq_vld.
- ins_rdy and deq_rdy are combinational from registers plus sel_idx/sel_vld. They must not depend on ins_vld or deq_req.
- The tree path vld_out → sel_idx → deq_rdy is combinational within one cycle.

## Structure
- Shared header pifo_pkg: clog2 function and the flat-vector slice macros, also used by the max stages.
- Sub-module prio_enc: lowest-zero finder over vld. Outputs the free index and a found flag.
- All remaining logic stays in one module.

## Test plan
Bench: REG_WIDTH=4, DATA_WIDTH=8, closed loop with a two-level tree of max stages feeding sel_idx/sel_vld.

- Reset → ins_rdy=1, deq_rdy=0, count=0, vld_out=4'b0000, deq_vld=0.
- Insert 5, 9, 3, 7 back-to-back → slots 0..3, vld_out=4'b1111, count=4, ins_rdy=0. A fifth insert (rank 1) is held, not stored.
- From full, deq_req for one cycle → the next cycle has deq_vld=1, deq_data=9 with slot 1's meta, vld_out=4'b1101, count=3. A following insert of 12 lands in slot 1.
- count=2 (slots 0,1), simultaneous insert 6 and dequeue → one entry leaves and 6 lands in slot 2 (not the freed slot), count=2.
- Equal ranks 4 in slots 0 and 2 → tree selects slot 2. Dequeue returns slot 2's meta, vld_out=4'b0001.
- Dequeue accepted with rst high on the same edge → deq_vld=0 next cycle, count=0, all vld_out=0.

Source files
------------

// File: rtl/pifo_pkg.sv
// Shared PIFO helpers: index-width function and flat-vector slice macros
// used by the register array and the max-selection stages.

`ifndef PIFO_PKG_MACROS
`define PIFO_PKG_MACROS
// Field i of a flat vector made of equal-width fields (field 0 at the LSBs).
`define PIFO_SLICE(vec, i, w) vec[((i) + 1) * (w) - 1 -: (w)]
`endif

package pifo_pkg;

  // Smallest n such that 2**n >= value (returns 1 for value <= 2).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned n;
    n = 1;
    while ((32'd1 << n) < value) begin
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-zero finder: returns the index of the lowest clear bit of vld.

module prio_enc
  import pifo_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vld,
  output logic [IDX_W-1:0] free_idx,
  output logic             found
);

  // Scan from the top down so the lowest free slot is the last one written.
  always_comb begin
    free_idx = '0;
    found    = 1'b0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (!vld[i-1]) begin
        free_idx = IDX_W'(i - 1);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pifo_reg_array.sv
// Register storage feeding the PIFO max-selection tree. Accepts entries on a
// valid/ready port, removes the tree-selected slot on dequeue and returns
// its rank/metadata one cycle later.

module pifo_reg_array
  import pifo_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned META_WIDTH = 10,
  parameter int unsigned IDX_WIDTH  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ins_vld,
  output logic                             ins_rdy,
  input  logic [DATA_WIDTH-1:0]            ins_data,
  input  logic [META_WIDTH-1:0]            ins_meta,
  input  logic                             deq_req,
  output logic                             deq_rdy,
  output logic                             deq_vld,
  output logic [DATA_WIDTH-1:0]            deq_data,
  output logic [META_WIDTH-1:0]            deq_meta,
  output logic [REG_WIDTH*DATA_WIDTH-1:0]  data_out,
  output logic [REG_WIDTH*META_WIDTH-1:0]  meta_out,
  output logic [REG_WIDTH*IDX_WIDTH-1:0]   idx_out,
  output logic [REG_WIDTH-1:0]             vld_out,
  input  logic [IDX_WIDTH-1:0]             sel_idx,
  input  logic                             sel_vld,
  output logic [IDX_WIDTH:0]               count
);

  logic [DATA_WIDTH-1:0] data_q [REG_WIDTH];
  logic [META_WIDTH-1:0] meta_q [REG_WIDTH];
  logic [REG_WIDTH-1:0]  vld_q;
  logic [IDX_WIDTH:0]    count_q;

  logic [IDX_WIDTH-1:0]  free_idx;
  logic                  free_found;
  logic                  full;
  logic                  ins_fire;
  logic                  deq_fire;

  // Free slot is chosen from pre-edge vld, so a slot freed this cycle is not reused.
  prio_enc #(
    .WIDTH (REG_WIDTH),
    .IDX_W (IDX_WIDTH)
  ) u_prio_enc (
    .vld      (vld_q),
    .free_idx (free_idx),
    .found    (free_found)
  );

  assign full     = (count_q == (IDX_WIDTH + 1)'(REG_WIDTH));
  assign ins_rdy  = !full;
  assign deq_rdy  = sel_vld && vld_q[sel_idx];
  assign ins_fire = ins_vld && ins_rdy && free_found;
  assign deq_fire = deq_req && deq_rdy;
  assign vld_out  = vld_q;
  assign count    = count_q;

  // Flatten slot registers straight onto the tree-facing buses.
  always_comb begin
    data_out = '0;
    meta_out = '0;
    idx_out  = '0;
    for (int unsigned i = 0; i < REG_WIDTH; i++) begin
      `PIFO_SLICE(data_out, i, DATA_WIDTH) = data_q[i];
      `PIFO_SLICE(meta_out, i, META_WIDTH) = meta_q[i];
      `PIFO_SLICE(idx_out, i, IDX_WIDTH)   = IDX_WIDTH'(i);
    end
  end

  // Slot storage, occupancy, occupancy count and registered dequeue output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_WIDTH; i++) begin
        data_q[i] <= '0;
        meta_q[i] <= '0;
      end
      vld_q    <= '0;
      count_q  <= '0;
      deq_vld  <= 1'b0;
      deq_data <= '0;
      deq_meta <= '0;
    end else begin
      // Insert and dequeue never target the same slot: one is free, the other occupied.
      if (ins_fire) begin
        data_q[free_idx] <= ins_data;
        meta_q[free_idx] <= ins_meta;
        vld_q[free_idx]  <= 1'b1;
      end
      if (deq_fire) begin
        vld_q[sel_idx] <= 1'b0;
        deq_data       <= data_q[sel_idx];
        deq_meta       <= meta_q[sel_idx];
      end
      deq_vld <= deq_fire;
      case ({ins_fire, deq_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_pifo_reg_array.sv
// Closed-loop bench: a two-level max tree drives sel_idx/sel_vld from the
// array outputs; a slot-level reference model predicts every output.

module tb_pifo_reg_array;

  localparam int unsigned RW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MW = 10;
  localparam int unsigned IW = 2;

  logic              clk;
  logic              rst;
  logic              ins_vld;
  logic              ins_rdy;
  logic [DW-1:0]     ins_data;
  logic [MW-1:0]     ins_meta;
  logic              deq_req;
  logic              deq_rdy;
  logic              deq_vld;
  logic [DW-1:0]     deq_data;
  logic [MW-1:0]     deq_meta;
  logic [RW*DW-1:0]  data_out;
  logic [RW*MW-1:0]  meta_out;
  logic [RW*IW-1:0]  idx_out;
  logic [RW-1:0]     vld_out;
  logic [IW-1:0]     sel_idx;
  logic              sel_vld;
  logic [IW:0]       count;

  pifo_reg_array #(
    .REG_WIDTH  (RW),
    .DATA_WIDTH (DW),
    .META_WIDTH (MW),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ins_vld  (ins_vld),
    .ins_rdy  (ins_rdy),
    .ins_data (ins_data),
    .ins_meta (ins_meta),
    .deq_req  (deq_req),
    .deq_rdy  (deq_rdy),
    .deq_vld  (deq_vld),
    .deq_data (deq_data),
    .deq_meta (deq_meta),
    .data_out (data_out),
    .meta_out (meta_out),
    .idx_out  (idx_out),
    .vld_out  (vld_out),
    .sel_idx  (sel_idx),
    .sel_vld  (sel_vld),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-level max tree; on equal ranks the higher-index input wins.
  logic          l_vld, r_vld;
  logic [DW-1:0] l_dat, r_dat;
  logic [IW-1:0] l_idx, r_idx;
  always_comb begin
    if (vld_out[1] && (!vld_out[0] || data_out[15:8] >= data_out[7:0])) begin
      l_dat = data_out[15:8]; l_idx = 2'd1;
    end else begin
      l_dat = data_out[7:0];  l_idx = 2'd0;
    end
    l_vld = vld_out[0] || vld_out[1];
    if (vld_out[3] && (!vld_out[2] || data_out[31:24] >= data_out[23:16])) begin
      r_dat = data_out[31:24]; r_idx = 2'd3;
    end else begin
      r_dat = data_out[23:16]; r_idx = 2'd2;
    end
    r_vld = vld_out[2] || vld_out[3];
    sel_vld = l_vld || r_vld;
    sel_idx = (r_vld && (!l_vld || r_dat >= l_dat)) ? r_idx : l_idx;
  end

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: slot contents, occupancy and last dequeued entry.
  logic [DW-1:0] m_data [RW];
  logic [MW-1:0] m_meta [RW];
  bit            m_vld  [RW];
  int unsigned   m_count;
  bit            m_deq_vld;
  logic [DW-1:0] m_deq_data;
  logic [MW-1:0] m_deq_meta;

  function automatic void model_reset();
    for (int i = 0; i < RW; i++) begin
      m_data[i] = '0; m_meta[i] = '0; m_vld[i] = 0;
    end
    m_count = 0; m_deq_vld = 0; m_deq_data = '0; m_deq_meta = '0;
  endfunction

  // One clock: drive, check ready flags, advance model, check post-edge state.
  task automatic step(input bit iv, input logic [DW-1:0] idat, input logic [MW-1:0] imeta,
                      input bit dq, input bit r);
    int  win;
    int  slot;
    bit  exp_irdy, exp_drdy;
    logic [RW*DW-1:0] e_data;
    logic [RW*MW-1:0] e_meta;
    logic [RW-1:0]    e_vld;
    ins_vld = iv; ins_data = idat; ins_meta = imeta; deq_req = dq; rst = r;
    #1;
    exp_irdy = (m_count != RW);
    exp_drdy = (m_count != 0);
    check("ins_rdy", 64'(ins_rdy), 64'(exp_irdy));
    check("deq_rdy", 64'(deq_rdy), 64'(exp_drdy));
    win = -1;
    for (int i = 0; i < RW; i++)
      if (m_vld[i] && (win < 0 || m_data[i] >= m_data[win])) win = i;
    slot = -1;
    for (int i = RW - 1; i >= 0; i--)
      if (!m_vld[i]) slot = i;
    if (r) begin
      model_reset();
    end else begin
      m_deq_vld = dq && exp_drdy;
      if (m_deq_vld) begin
        m_deq_data = m_data[win]; m_deq_meta = m_meta[win];
        m_vld[win] = 0; m_count--;
      end
      if (iv && exp_irdy) begin
        m_data[slot] = idat; m_meta[slot] = imeta; m_vld[slot] = 1; m_count++;
      end
    end
    @(posedge clk);
    #1;
    ins_vld = 0; deq_req = 0; rst = 0;
    for (int i = 0; i < RW; i++) begin
      e_data[i*DW +: DW] = m_data[i];
      e_meta[i*MW +: MW] = m_meta[i];
      e_vld[i] = m_vld[i];
    end
    check("vld_out",  64'(vld_out),  64'(e_vld));
    check("count",    64'(count),    64'(m_count));
    check("deq_vld",  64'(deq_vld),  64'(m_deq_vld));
    check("deq_data", 64'(deq_data), 64'(m_deq_data));
    check("deq_meta", 64'(deq_meta), 64'(m_deq_meta));
    check("data_out", 64'(data_out), 64'(e_data));
    check("meta_out", 64'(meta_out), 64'(e_meta));
  endtask

  initial begin
    ins_vld = 0; ins_data = '0; ins_meta = '0; deq_req = 0; rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    check("idx_out", 64'(idx_out), 64'(8'b11_10_01_00));

    // Idle after reset: ready flags and empty state.
    step(0, 0, 0, 0, 0);
    check("rst_ins_rdy", 64'(ins_rdy), 64'(1));
    check("rst_deq_rdy", 64'(deq_rdy), 64'(0));

    // Fill 5,9,3,7 then a held fifth insert.
    step(1, 8'd5, 10'h105, 0, 0);
    step(1, 8'd9, 10'h109, 0, 0);
    step(1, 8'd3, 10'h103, 0, 0);
    step(1, 8'd7, 10'h107, 0, 0);
    check("full_vld", 64'(vld_out), 64'(4'b1111));
    step(1, 8'd1, 10'h101, 0, 0);

    // Dequeue the 9 from slot 1, then refill slot 1 with 12.
    step(0, 0, 0, 1, 0);
    check("deq9_data", 64'(deq_data), 64'(9));
    check("deq9_meta", 64'(deq_meta), 64'(10'h109));
    check("deq9_vld",  64'(vld_out),  64'(4'b1101));
    step(1, 8'd12, 10'h10c, 0, 0);
    check("ins12_slot", 64'(data_out[15:8]), 64'(12));

    // Two entries, simultaneous insert 6 and dequeue.
    step(0, 0, 0, 0, 1);
    step(1, 8'd2, 10'h202, 0, 0);
    step(1, 8'd8, 10'h208, 0, 0);
    step(1, 8'd6, 10'h206, 1, 0);
    check("sim_slot2", 64'(data_out[23:16]), 64'(6));
    check("sim_count", 64'(count), 64'(2));

    // Tie between slots 0 and 2 resolves to slot 2.
    step(0, 0, 0, 0, 1);
    step(1, 8'd4, 10'h300, 0, 0);
    step(1, 8'd9, 10'h301, 0, 0);
    step(1, 8'd4, 10'h302, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("tie_meta", 64'(deq_meta), 64'(10'h302));
    check("tie_vld",  64'(vld_out),  64'(4'b0001));

    // Reset on the same edge as an accepted dequeue.
    step(1, 8'd3, 10'h303, 0, 0);
    step(0, 0, 0, 1, 1);
    check("rstdeq_vld", 64'(deq_vld), 64'(0));

    // Randomized traffic with small rank range to provoke ties.
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(0, 99) < 55), DW'($urandom_range(0, 15)), MW'($urandom),
           bit'($urandom_range(0, 99) < 45), bit'($urandom_range(0, 99) < 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
